// File: rtl/rhs2116_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | Module  : rhs2116_spi_responder                                                  |
// | Purpose : RHS2116-style SPI mode-1 slave with 32-bit frames and a pipelined      |
// |           response queue, used for loopback and bench tests with no chip fitted. |
// | Option  : RHS_RESPONDER_SYNC_EN adds a 2-FF synchronizer on cs_n/sclk/mosi.      |
// | Rev     : 1.0  initial release                                                   |
// +----------------------------------------------------------------------------------+
module rhs2116_spi_responder #(
  parameter int          LATENCY     = 2,
  parameter logic [11:0] SAMPLE_SEED = 12'h000
) (
  input  logic        clk_spi,
  input  logic        rst,
  input  logic        enable,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic [31:0] cmd_out,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  logic w_cs_in, w_sclk_in, w_mosi_in;

`ifdef RHS_RESPONDER_SYNC_EN
  logic [1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
  always_ff @(posedge clk_spi) begin
    if (rst) begin
      r_cs_sync   <= 2'b00;
      r_sclk_sync <= 2'b00;
      r_mosi_sync <= 2'b00;
    end else begin
      r_cs_sync   <= {r_cs_sync[0], cs_n};
      r_sclk_sync <= {r_sclk_sync[0], sclk};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
    end
  end
  assign w_cs_in   = r_cs_sync[1];
  assign w_sclk_in = r_sclk_sync[1];
  assign w_mosi_in = r_mosi_sync[1];
`else
  assign w_cs_in   = cs_n;
  assign w_sclk_in = sclk;
  assign w_mosi_in = mosi;
`endif

  // cs_n history resets low so a frame already in progress at reset release shows no falling edge
  logic r_cs_s1, r_cs_s2, r_sclk_s1, r_sclk_s2, r_mosi_s1;
  always_ff @(posedge clk_spi) begin
    if (rst) begin
      r_cs_s1   <= 1'b0;
      r_cs_s2   <= 1'b0;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_mosi_s1 <= 1'b0;
    end else begin
      r_cs_s1   <= w_cs_in;
      r_cs_s2   <= r_cs_s1;
      r_sclk_s1 <= w_sclk_in;
      r_sclk_s2 <= r_sclk_s1;
      r_mosi_s1 <= w_mosi_in;
    end
  end

  logic w_cs_fall, w_cs_rise, w_sclk_fall;
  assign w_cs_fall   = r_cs_s2 & ~r_cs_s1;
  assign w_cs_rise   = ~r_cs_s2 & r_cs_s1;
  assign w_sclk_fall = r_sclk_s2 & ~r_sclk_s1;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_bit_cnt, w_bit_cnt_inc, w_bit_cnt_nxt;
  logic [31:0] r_rx_sh, r_tx_sh;
  logic [31:0] r_q   [LATENCY];
  logic [11:0] r_cnt [16];
  logic        w_load, w_shift, w_commit, w_err;

  assign w_bit_cnt_inc = (r_bit_cnt == 6'd33) ? 6'd33 : r_bit_cnt + 6'd1;
  assign w_bit_cnt_nxt = w_sclk_fall ? w_bit_cnt_inc : r_bit_cnt;

  always_ff @(posedge clk_spi) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // The CS-rise test uses the post-shift bit count so a final SCLK fall in the same cycle still counts
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            w_state_nxt = ST_ACTIVE;
            w_load      = 1'b1;
          end
        end
        ST_ACTIVE: begin
          w_shift = w_sclk_fall;
          if (w_cs_rise) begin
            if (w_bit_cnt_nxt == 6'd32) begin
              w_state_nxt = ST_COMMIT;
            end else begin
              w_state_nxt = ST_IDLE;
              w_err       = 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  logic [3:0]  w_ch;
  logic        w_is_conv;
  logic [31:0] w_resp;
  assign w_ch      = r_rx_sh[19:16];
  assign w_is_conv = (r_rx_sh[31:30] == 2'b00);
  assign w_resp    = w_is_conv ? {4'hC, r_rx_sh[21:16], 6'b0, w_ch, r_cnt[w_ch]}
                               : {2'b10, 14'b0, r_rx_sh[31:16]};

  always_ff @(posedge clk_spi) begin
    if (rst) begin
      r_bit_cnt <= 6'd0;
      r_rx_sh   <= 32'h0;
      r_tx_sh   <= 32'h0;
      cmd_out   <= 32'h0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= 16'h0;
      for (int i = 0; i < LATENCY; i++) r_q[i] <= 32'h0;
      for (int i = 0; i < 16; i++) r_cnt[i] <= SAMPLE_SEED;
    end else begin
      cmd_valid <= w_commit;
      frame_err <= w_err;
      if (w_load) begin
        r_bit_cnt <= 6'd0;
        r_tx_sh   <= r_q[LATENCY-1];
      end else if (w_shift) begin
        r_bit_cnt <= w_bit_cnt_inc;
        r_rx_sh   <= {r_rx_sh[30:0], r_mosi_s1};
        r_tx_sh   <= {r_tx_sh[30:0], 1'b0};
      end
      if (w_commit) begin
        cmd_out   <= r_rx_sh;
        frame_cnt <= frame_cnt + 16'd1;
        for (int i = LATENCY - 1; i > 0; i--) r_q[i] <= r_q[i-1];
        r_q[0] <= w_resp;
        if (w_is_conv) r_cnt[w_ch] <= r_cnt[w_ch] + 12'd1;
      end
    end
  end

  assign miso = enable & (r_state == ST_ACTIVE) & r_tx_sh[31];

endmodule
`default_nettype wire

// File: tb/tb_rhs2116_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | Module  : tb_rhs2116_spi_responder                                               |
// | Purpose : Randomized SPI master driving rhs2116_spi_responder against a          |
// |           queue-based response model.                                            |
// | Rev     : 1.0  initial release                                                   |
// +----------------------------------------------------------------------------------+
module tb_rhs2116_spi_responder;

  localparam int          LAT  = 2;
  localparam logic [11:0] SEED = 12'hFFD;
  localparam int          HALF = 3;
`ifdef RHS_RESPONDER_SYNC_EN
  localparam int LAT_EXP = 5;
`else
  localparam int LAT_EXP = 3;
`endif

  logic        clk_spi, rst, enable, cs_n, sclk, mosi;
  logic        miso, cmd_valid, frame_err;
  logic [31:0] cmd_out;
  logic [15:0] frame_cnt;

  rhs2116_spi_responder #(.LATENCY(LAT), .SAMPLE_SEED(SEED)) dut (
    .clk_spi(clk_spi), .rst(rst), .enable(enable), .cs_n(cs_n), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cmd_out(cmd_out), .cmd_valid(cmd_valid),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  initial clk_spi = 1'b0;
  always #5 clk_spi = ~clk_spi;

  int n_cmp = 0;
  int n_mis = 0;
  int n_valid = 0;
  int n_err = 0;

  always @(negedge clk_spi) begin
    if (cmd_valid) n_valid++;
    if (frame_err) n_err++;
  end

  // Reference model: FIFO of pending responses, per-channel sample counters
  logic [31:0] mq[$];
  logic [11:0] mcnt[16];
  logic [31:0] mcmd;
  int          mframes;

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < LAT; i++) mq.push_back(32'h0);
    for (int i = 0; i < 16; i++) mcnt[i] = SEED;
    mcmd    = 32'h0;
    mframes = 0;
  endfunction

  function automatic logic [31:0] model_resp(input logic [31:0] cmd);
    logic [31:0] r;
    int          ch;
    if (cmd[31:30] == 2'b00) begin
      ch = int'(cmd[19:16]);
      r  = 32'hC000_0000 + (32'(cmd[21:16]) << 22) + (32'(ch) << 12) + 32'(mcnt[ch]);
      mcnt[ch] = mcnt[ch] + 12'd1;
    end else begin
      r = 32'h8000_0000 + 32'(cmd[31:16]);
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Mode 1 master: MOSI changes on SCLK rise, MISO sampled on SCLK fall
  task automatic spi_xfer(input logic [31:0] cmd, input int nbits, input int drop_at,
                          input int rst_at, output logic [31:0] rx, output int lat);
    @(negedge clk_spi);
    cs_n = 1'b0;
    repeat (4) @(negedge clk_spi);
    rx = 32'h0;
    for (int i = 0; i < nbits; i++) begin
      if (i == drop_at) enable = 1'b0;
      if (drop_at >= 0 && i == drop_at + 1) check_eq("miso_disabled", {31'h0, miso}, 32'h0);
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk_spi);
        rst = 1'b0;
      end
      sclk = 1'b1;
      mosi = cmd[31 - (i % 32)];
      repeat (HALF) @(negedge clk_spi);
      rx   = {rx[30:0], miso};
      sclk = 1'b0;
      repeat (HALF) @(negedge clk_spi);
    end
    repeat (2) @(negedge clk_spi);
    cs_n = 1'b1;
    mosi = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_spi);
      if (cmd_valid && lat == 0) lat = k;
    end
  endtask

  task automatic good_frame(input logic [31:0] cmd);
    int          v0, e0, lat;
    logic [31:0] rx, expm;
    v0   = n_valid;
    e0   = n_err;
    expm = mq[0];
    spi_xfer(cmd, 32, -1, -1, rx, lat);
    mframes++;
    mcmd = cmd;
    check_eq("miso_word", rx, expm);
    check_eq("cmd_out", cmd_out, cmd);
    check_eq("valid_pulses", 32'(n_valid - v0), 32'd1);
    check_eq("err_pulses", 32'(n_err - e0), 32'd0);
    check_eq("valid_latency", 32'(lat), 32'(LAT_EXP));
    check_eq("frame_cnt", {16'h0, frame_cnt}, 32'(mframes & 16'hFFFF));
    void'(mq.pop_front());
    mq.push_back(model_resp(cmd));
  endtask

  task automatic bad_frame(input logic [31:0] cmd, input int nbits);
    int          v0, e0, lat;
    logic [31:0] rx, expm;
    v0   = n_valid;
    e0   = n_err;
    expm = (nbits <= 32) ? (mq[0] >> (32 - nbits)) : (mq[0] << 1);
    spi_xfer(cmd, nbits, -1, -1, rx, lat);
    check_eq("short_miso", rx, expm);
    check_eq("short_err_pulses", 32'(n_err - e0), 32'd1);
    check_eq("short_valid_pulses", 32'(n_valid - v0), 32'd0);
    check_eq("short_cmd_out", cmd_out, mcmd);
    check_eq("short_frame_cnt", {16'h0, frame_cnt}, 32'(mframes & 16'hFFFF));
  endtask

  function automatic logic [31:0] rand_cmd();
    logic [31:0] c;
    c = $urandom;
    if ($urandom_range(0, 2) != 0) begin
      c[31:30] = 2'b00;
      c[19:16] = 4'($urandom_range(0, 3));
    end else if (c[31:30] == 2'b00) begin
      c[31] = 1'b1;
    end
    return c;
  endfunction

  initial begin
    int          v0, e0, lat;
    logic [31:0] rx, expm;

    rst = 1'b1; enable = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_spi);
    check_eq("rst_miso", {31'h0, miso}, 32'h0);
    check_eq("rst_cmd_out", cmd_out, 32'h0);
    check_eq("rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check_eq("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check_eq("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk_spi);

    for (int ch = 0; ch < 4; ch++) good_frame(32'h0010_0000 | (32'(ch) << 16));
    good_frame(32'h0015_0000);
    good_frame(32'h0015_0000);
    good_frame(32'hC0FF_0000);
    good_frame(32'h0010_0000);
    good_frame(32'h0010_0000);

    bad_frame(32'h0011_0000, 20);
    good_frame(32'h4000_1234);
    bad_frame(32'h0012_0000, 33);
    good_frame(32'h0012_0000);

    // enable dropped mid-frame: frame vanishes silently, queue intact
    v0 = n_valid; e0 = n_err; expm = mq[0];
    spi_xfer(32'h0013_0000, 32, 10, -1, rx, lat);
    enable = 1'b1;
    check_eq("dis_miso_head", rx >> 22, expm >> 22);
    check_eq("dis_valid_pulses", 32'(n_valid - v0), 32'd0);
    check_eq("dis_err_pulses", 32'(n_err - e0), 32'd0);
    check_eq("dis_cmd_out", cmd_out, mcmd);
    good_frame(32'h0013_0000);
    good_frame(32'h8ABC_0000);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 5) == 0) bad_frame(rand_cmd(), int'($urandom_range(1, 31)));
      else good_frame(rand_cmd());
      repeat ($urandom_range(0, 6)) @(negedge clk_spi);
    end

    // reset mid-frame: remainder of that frame must be ignored
    v0 = n_valid; e0 = n_err;
    spi_xfer(32'h0011_0000, 32, -1, 12, rx, lat);
    model_reset();
    check_eq("rstmid_valid_pulses", 32'(n_valid - v0), 32'd0);
    check_eq("rstmid_err_pulses", 32'(n_err - e0), 32'd0);
    check_eq("rstmid_cmd_out", cmd_out, 32'h0);
    check_eq("rstmid_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    for (int n = 0; n < 6; n++) good_frame(32'h0010_0000 | (32'(n % 2) << 16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
